ip_codma_bus_arbiter: RTL and testbench
=======================================

Name: ip_codma_bus_arbiter

Overview:
Shares the single system bus master port between the CODMA read machine and write machine. Each transfer is granted atomically: the arbiter issues the bus request, waits for the bus grant, and counts data beats until the transfer completes. It then releases ownership using round-robin priority. It sits between the read and write machines and the bus interface, and reports completion, errors and timeouts back to the machines.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait in ARB_REQ for bus_grant_i before abandoning (1..255).
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  asynchronous, active-high reset.
stop_i  in  1  abort any transfer, return to idle.
rd_req_i  in  1  read machine requests the bus; level, held until done/err.
rd_size_i  in  4  read transfer size code (3, 8 or 9).
rd_grant_o  out  1  read machine owns the data phase.
rd_done_o  out  1  one-cycle pulse: read transfer completed.
wr_req_i  in  1  write machine requests the bus.
wr_size_i  in  4  write transfer size code.
wr_grant_o  out  1  write machine owns the data phase.
wr_done_o  out  1  one-cycle pulse: write transfer completed.
bus_req_o  out  1  request to the system bus.
bus_write_o  out  1  1 = current owner is the write machine.
bus_size_o  out  4  latched size code of the current transfer.
bus_grant_i  in  1  bus grant.
bus_ack_i  in  1  one data beat accepted this cycle.
bus_error_i  in  1  bus error.
beat_count_o  out  2  beats completed in the current transfer.
err_o  out  1  one-cycle pulse: illegal size, bus error or timeout.
timeout_o  out  1  one-cycle pulse: grant timeout (err_o also pulses).

Behaviour:
- Reset (async, reset_i=1):
  - All outputs 0; state ARB_IDLE.
  - last_owner = WR, so RD wins the first tie.
  - Counters 0.
- Size decode (beats): 3→1, 8→2, 9→4. Any other code is illegal.
- States: ARB_IDLE, ARB_REQ, ARB_BUSY, ARB_DONE.
- ARB_IDLE:
  - With one request, select that requester. With both, select the one that is not last_owner.
  - Latch owner and size.
  - Illegal size: pulse err_o next cycle, set last_owner to the offender, stay in ARB_IDLE, no bus_req_o.
  - Legal size: go to ARB_REQ; bus_req_o=1 from the next cycle.
- ARB_REQ:
  - bus_req_o=1; bus_write_o and bus_size_o reflect the latched transfer.
  - bus_grant_i=1 → ARB_BUSY; the owner's grant output rises next cycle.
  - Timeout counter increments each cycle. Reaching TIMEOUT_CYCLES → ARB_IDLE, pulse timeout_o and err_o, set last_owner to the owner.
  - Owner's req deasserted before grant → ARB_IDLE silently, last_owner unchanged.
- ARB_BUSY:
  - bus_req_o=1; owner grant=1.
  - Each bus_ack_i increments beat_count_o.
  - Ack on beat (beats-1) → ARB_DONE.
  - Req deassertion here is ignored.
- ARB_DONE (one cycle):
  - Grants, bus_req_o and beat_count_o go to 0.
  - Owner's done pulse is 1; last_owner updated.
  - Next state ARB_IDLE.
- Priority per cycle: stop_i > bus_error_i > bus_ack_i/grant/timeout.
  - stop_i in any state → ARB_IDLE next cycle. No done or err pulse, last_owner unchanged, counters cleared.
  - bus_error_i in ARB_REQ or ARB_BUSY → ARB_IDLE next cycle, pulse err_o, no done, last_owner updated to the owner.
  - bus_error_i in ARB_IDLE or ARB_DONE is ignored.
- Latency:
  - Req seen in IDLE at cycle N → bus_req_o at N+1.
  - Grant at cycle M → owner grant at M+1.
  - Final ack at cycle K → done pulse at K+1, IDLE at K+2.
  - Earliest next bus_req_o is K+3.
- Never both rd_grant_o and wr_grant_o high. bus_req_o is only high in ARB_REQ and ARB_BUSY.

Test Plan:
- RD only, size 9, grant after 3 cycles, 4 acks → rd_grant_o high 4+ cycles, beat_count_o 0→3, rd_done_o single pulse, wr_grant_o stays 0.
- RD and WR both request at once, size 8, repeated back-to-back → grants alternate RD, WR, RD, WR; each completes after 2 acks; bus_write_o matches the owner.
- WR size 5 → err_o one pulse, bus_req_o never rises; a following RD size 3 is granted and completes after 1 ack.
- TIMEOUT_CYCLES=4, RD request with bus_grant_i held 0 → timeout_o and err_o pulse together; bus_req_o drops after exactly 4 cycles in ARB_REQ.
- bus_error_i after the 1st ack of a size-9 WR → IDLE next cycle, err_o pulse, no wr_done_o; a pending RD is granted next.
- stop_i in ARB_BUSY, and separately reset_i asserted mid-transfer → all outputs 0 immediately on reset, IDLE next cycle on stop, no done pulse.

Source files
------------

// File: rtl/ip_codma_bus_arbiter_if.sv
// rtl/ip_codma_bus_arbiter_if.sv - request/grant and system bus signals around the CODMA bus arbiter
interface ip_codma_bus_arbiter_if;
    logic       stop_i;
    logic       rd_req_i;
    logic [3:0] rd_size_i;
    logic       rd_grant_o;
    logic       rd_done_o;
    logic       wr_req_i;
    logic [3:0] wr_size_i;
    logic       wr_grant_o;
    logic       wr_done_o;
    logic       bus_req_o;
    logic       bus_write_o;
    logic [3:0] bus_size_o;
    logic       bus_grant_i;
    logic       bus_ack_i;
    logic       bus_error_i;
    logic [1:0] beat_count_o;
    logic       err_o;
    logic       timeout_o;

    // Arbiter side
    modport master (
        input  stop_i, rd_req_i, rd_size_i, wr_req_i, wr_size_i,
               bus_grant_i, bus_ack_i, bus_error_i,
        output rd_grant_o, rd_done_o, wr_grant_o, wr_done_o,
               bus_req_o, bus_write_o, bus_size_o, beat_count_o, err_o, timeout_o
    );

    // Read/write machines and bus side
    modport slave (
        output stop_i, rd_req_i, rd_size_i, wr_req_i, wr_size_i,
               bus_grant_i, bus_ack_i, bus_error_i,
        input  rd_grant_o, rd_done_o, wr_grant_o, wr_done_o,
               bus_req_o, bus_write_o, bus_size_o, beat_count_o, err_o, timeout_o
    );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// rtl/ip_codma_bus_arbiter.sv - round-robin owner of the single system bus master port
module ip_codma_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    ip_codma_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_BUSY, ARB_DONE} arb_state_e;

    localparam logic            OWN_RD  = 1'b0;
    localparam logic            OWN_WR  = 1'b1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [3:0]      size_q, size_d;
    logic [1:0]      last_beat_q, last_beat_d;
    logic [1:0]      beat_q, beat_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            timeout_q, timeout_d;

    logic       sel_wr;
    logic [3:0] sel_size;
    logic       sel_legal;
    logic [1:0] sel_last;
    logic       owner_req;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_RD;
            last_owner_q <= OWN_WR;
            size_q       <= '0;
            last_beat_q  <= '0;
            beat_q       <= '0;
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            size_q       <= size_d;
            last_beat_q  <= last_beat_d;
            beat_q       <= beat_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
        end
    end

    // On a tie the machine that did not own the bus last wins
    assign sel_wr    = bus.wr_req_i && (!bus.rd_req_i || (last_owner_q == OWN_RD));
    assign sel_size  = sel_wr ? bus.wr_size_i : bus.rd_size_i;
    assign owner_req = (owner_q == OWN_WR) ? bus.wr_req_i : bus.rd_req_i;

    // last_beat holds the index of the final beat: 1, 2 or 4 beats
    always_comb begin
        sel_legal = 1'b1;
        sel_last  = 2'd0;
        case (sel_size)
            4'd3:    sel_last = 2'd0;
            4'd8:    sel_last = 2'd1;
            4'd9:    sel_last = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        size_d       = size_q;
        last_beat_d  = last_beat_q;
        beat_d       = beat_q;
        to_cnt_d     = to_cnt_q;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        if (bus.stop_i) begin
            state_d  = ARB_IDLE;
            beat_d   = '0;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (bus.rd_req_i || bus.wr_req_i) begin
                        owner_d     = sel_wr;
                        size_d      = sel_size;
                        last_beat_d = sel_last;
                        to_cnt_d    = '0;
                        if (sel_legal) begin
                            state_d = ARB_REQ;
                        end else begin
                            err_d        = 1'b1;
                            last_owner_d = sel_wr;
                        end
                    end
                end
                ARB_REQ: begin
                    if (bus.bus_error_i) begin
                        state_d      = ARB_IDLE;
                        err_d        = 1'b1;
                        last_owner_d = owner_q;
                        to_cnt_d     = '0;
                    end else if (!owner_req) begin
                        state_d  = ARB_IDLE;
                        to_cnt_d = '0;
                    end else if (bus.bus_grant_i) begin
                        state_d  = ARB_BUSY;
                        beat_d   = '0;
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d      = ARB_IDLE;
                        err_d        = 1'b1;
                        timeout_d    = 1'b1;
                        last_owner_d = owner_q;
                        to_cnt_d     = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (bus.bus_error_i) begin
                        state_d      = ARB_IDLE;
                        err_d        = 1'b1;
                        last_owner_d = owner_q;
                        beat_d       = '0;
                    end else if (bus.bus_ack_i) begin
                        if (beat_q == last_beat_q) begin
                            state_d = ARB_DONE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                ARB_DONE: begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    logic active;
    assign active = (state_q == ARB_REQ) || (state_q == ARB_BUSY);

    assign bus.bus_req_o    = active;
    assign bus.bus_write_o  = active && (owner_q == OWN_WR);
    assign bus.bus_size_o   = active ? size_q : 4'd0;
    assign bus.rd_grant_o   = (state_q == ARB_BUSY) && (owner_q == OWN_RD);
    assign bus.wr_grant_o   = (state_q == ARB_BUSY) && (owner_q == OWN_WR);
    assign bus.rd_done_o    = (state_q == ARB_DONE) && (owner_q == OWN_RD);
    assign bus.wr_done_o    = (state_q == ARB_DONE) && (owner_q == OWN_WR);
    assign bus.beat_count_o = beat_q;
    assign bus.err_o        = err_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// tb/tb_ip_codma_bus_arbiter.sv - scoreboard bench for the CODMA bus arbiter
module tb_ip_codma_bus_arbiter;
    localparam logic [3:0] EV_RD  = 4'b0001;
    localparam logic [3:0] EV_WR  = 4'b0010;
    localparam logic [3:0] EV_ERR = 4'b0100;
    localparam logic [3:0] EV_TO  = 4'b1100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] exp_q[$];

    ip_codma_bus_arbiter_if ifc();

    ip_codma_bus_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event monitor: every completion/error pulse must match the next expected event
    always @(posedge clk) begin
        logic [3:0] ev;
        #1;
        ev = {ifc.timeout_o, ifc.err_o, ifc.wr_done_o, ifc.rd_done_o};
        check_eq("grant_excl", {31'd0, ifc.rd_grant_o & ifc.wr_grant_o}, 32'd0);
        if (ifc.rd_grant_o || ifc.wr_grant_o)
            check_eq("bus_write_owner", {31'd0, ifc.bus_write_o}, {31'd0, ifc.wr_grant_o});
        if (ev != 4'd0) begin
            if (exp_q.size() == 0) check_eq("unexpected_event", {28'd0, ev}, 32'd0);
            else check_eq("event", {28'd0, ev}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ifc.stop_i = 0; ifc.rd_req_i = 0; ifc.wr_req_i = 0;
        ifc.rd_size_i = 0; ifc.wr_size_i = 0;
        ifc.bus_grant_i = 0; ifc.bus_ack_i = 0; ifc.bus_error_i = 0;
        tick();
        tick();
        check_eq("reset_outputs", {11'd0, ifc.rd_grant_o, ifc.rd_done_o, ifc.wr_grant_o, ifc.wr_done_o,
                 ifc.bus_req_o, ifc.bus_write_o, ifc.bus_size_o, ifc.beat_count_o, ifc.err_o,
                 ifc.timeout_o, 7'd0}, 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_bus_req(input int budget, input string tag);
        for (int i = 0; i < budget && !ifc.bus_req_o; i++) tick();
        check_eq(tag, {31'd0, ifc.bus_req_o}, 32'd1);
    endtask

    // Bus side of one transfer: grant after gdly REQ cycles, then ack every beat
    task automatic serve(input bit exp_wr, input int beats, input int gdly, input logic [3:0] exp_size);
        wait_bus_req(20, "wait_bus_req");
        check_eq("bus_write", {31'd0, ifc.bus_write_o}, {31'd0, exp_wr});
        check_eq("bus_size", {28'd0, ifc.bus_size_o}, {28'd0, exp_size});
        repeat (gdly) begin
            tick();
            check_eq("req_hold", {31'd0, ifc.bus_req_o}, 32'd1);
        end
        ifc.bus_grant_i = 1'b1;
        tick();
        ifc.bus_grant_i = 1'b0;
        check_eq("rd_grant", {31'd0, ifc.rd_grant_o}, {31'd0, !exp_wr});
        check_eq("wr_grant", {31'd0, ifc.wr_grant_o}, {31'd0, exp_wr});
        exp_q.push_back(exp_wr ? EV_WR : EV_RD);
        for (int i = 0; i < beats; i++) begin
            check_eq("beat_count", {30'd0, ifc.beat_count_o}, i);
            check_eq("grant_held", {31'd0, exp_wr ? ifc.wr_grant_o : ifc.rd_grant_o}, 32'd1);
            ifc.bus_ack_i = 1'b1;
            tick();
            ifc.bus_ack_i = 1'b0;
        end
        check_eq("done_pulse", {31'd0, exp_wr ? ifc.wr_done_o : ifc.rd_done_o}, 32'd1);
        check_eq("done_beat0", {30'd0, ifc.beat_count_o}, 32'd0);
        check_eq("done_req0", {31'd0, ifc.bus_req_o}, 32'd0);
        check_eq("done_grant0", {30'd0, ifc.rd_grant_o, ifc.wr_grant_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // RD only, size 9, grant in the third REQ cycle, four beats
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd9;
        tick();
        check_eq("req_latency", {31'd0, ifc.bus_req_o}, 32'd1);
        serve(1'b0, 4, 2, 4'd9);
        ifc.rd_req_i = 0;
        tick();
        check_eq("rd_done_single", {31'd0, ifc.rd_done_o}, 32'd0);
        check_eq("idle_req", {31'd0, ifc.bus_req_o}, 32'd0);

        // Both request back to back: RD wins first after reset, then alternate
        do_reset();
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd8;
        ifc.wr_req_i = 1; ifc.wr_size_i = 4'd8;
        for (int t = 0; t < 4; t++) serve(t[0], 2, 0, 4'd8);
        ifc.rd_req_i = 0; ifc.wr_req_i = 0;
        tick();
        tick();
        check_eq("rr_idle", {31'd0, ifc.bus_req_o}, 32'd0);

        // Illegal WR size, then a legal single-beat RD
        ifc.wr_req_i = 1; ifc.wr_size_i = 4'd5;
        exp_q.push_back(EV_ERR);
        tick();
        ifc.wr_req_i = 0;
        check_eq("illegal_err", {31'd0, ifc.err_o}, 32'd1);
        check_eq("illegal_noreq", {31'd0, ifc.bus_req_o}, 32'd0);
        tick();
        check_eq("illegal_err_pulse", {31'd0, ifc.err_o}, 32'd0);
        check_eq("illegal_noreq2", {31'd0, ifc.bus_req_o}, 32'd0);
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd3;
        serve(1'b0, 1, 0, 4'd3);
        ifc.rd_req_i = 0;
        tick();

        // Grant never comes: exactly four cycles in REQ, then timeout
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd3;
        exp_q.push_back(EV_TO);
        tick();
        n = 0;
        while (ifc.bus_req_o && n < 20) begin
            n++;
            tick();
        end
        ifc.rd_req_i = 0;
        check_eq("timeout_cycles", n, 32'd4);
        check_eq("timeout_pulse", {30'd0, ifc.timeout_o, ifc.err_o}, 32'd3);
        tick();
        check_eq("timeout_once", {30'd0, ifc.timeout_o, ifc.err_o}, 32'd0);

        // Bus error after the first ack of a size-9 WR, pending RD follows
        ifc.wr_req_i = 1; ifc.wr_size_i = 4'd9;
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd3;
        wait_bus_req(20, "berr_wait_req");
        check_eq("berr_owner_wr", {31'd0, ifc.bus_write_o}, 32'd1);
        ifc.bus_grant_i = 1;
        tick();
        ifc.bus_grant_i = 0;
        ifc.bus_ack_i = 1;
        tick();
        ifc.bus_ack_i = 0;
        check_eq("berr_beat1", {30'd0, ifc.beat_count_o}, 32'd1);
        ifc.bus_error_i = 1;
        exp_q.push_back(EV_ERR);
        tick();
        ifc.bus_error_i = 0;
        ifc.wr_req_i = 0;
        check_eq("berr_err", {31'd0, ifc.err_o}, 32'd1);
        check_eq("berr_idle", {30'd0, ifc.bus_req_o, ifc.wr_grant_o}, 32'd0);
        check_eq("berr_nodone", {31'd0, ifc.wr_done_o}, 32'd0);
        serve(1'b0, 1, 0, 4'd3);
        ifc.rd_req_i = 0;
        tick();

        // stop in BUSY: idle next cycle, no pulses
        ifc.rd_req_i = 1; ifc.rd_size_i = 4'd9;
        wait_bus_req(20, "stop_wait_req");
        ifc.bus_grant_i = 1;
        tick();
        ifc.bus_grant_i = 0;
        ifc.bus_ack_i = 1;
        tick();
        ifc.bus_ack_i = 0;
        ifc.stop_i = 1;
        tick();
        ifc.stop_i = 0;
        ifc.rd_req_i = 0;
        check_eq("stop_idle", {29'd0, ifc.bus_req_o, ifc.rd_grant_o, ifc.rd_done_o}, 32'd0);
        check_eq("stop_beat0", {30'd0, ifc.beat_count_o}, 32'd0);
        tick();

        // Asynchronous reset mid-transfer clears outputs without waiting for a clock
        ifc.wr_req_i = 1; ifc.wr_size_i = 4'd8;
        wait_bus_req(20, "rst_wait_req");
        ifc.bus_grant_i = 1;
        tick();
        ifc.bus_grant_i = 0;
        check_eq("rst_pre_grant", {31'd0, ifc.wr_grant_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_async", {21'd0, ifc.bus_req_o, ifc.wr_grant_o, ifc.bus_write_o,
                 ifc.bus_size_o, ifc.beat_count_o, ifc.wr_done_o}, 32'd0);
        ifc.wr_req_i = 0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_idle", {31'd0, ifc.bus_req_o}, 32'd0);

        tick();
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
